// File: rtl/rst_sequencer.sv
// Staged reset sequencer: holds the serdes and video-core resets until lock is stable, then releases them in order.
// Optional MMCM watchdog/retry logic is compiled in with `define RST_SEQ_WDOG_EN.
module rst_sequencer #(
    parameter logic P_SRST_POLARITY   = 1'b1,
    parameter int   P_LOCK_CYCLES     = 16,
    parameter int   P_STAGE_CYCLES    = 8,
    parameter int   P_WDOG_CYCLES     = 1024,
    parameter int   P_MMCM_RST_CYCLES = 4
) (
    input  logic       i_sclk,
    input  logic       i_arst,
    input  logic       i_locked,
    output logic       o_rst_serdes,
    output logic       o_rst_core,
    output logic       o_ready,
    output logic       o_lost_lock,
    output logic       o_mmcm_rst,
    output logic [3:0] o_retry_cnt,
    output logic [2:0] o_dbg_state
);

    localparam int CNT_MAX_LS = (P_LOCK_CYCLES > P_STAGE_CYCLES) ? P_LOCK_CYCLES : P_STAGE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_LS > P_MMCM_RST_CYCLES) ? CNT_MAX_LS : P_MMCM_RST_CYCLES;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    if (P_LOCK_CYCLES < 1 || P_STAGE_CYCLES < 1 || P_WDOG_CYCLES < 1 || P_MMCM_RST_CYCLES < 1) begin : g_bad_param
        $error("rst_sequencer: all cycle-count parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        S_HOLD       = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABLE     = 3'd2,
        S_REL_SERDES = 3'd3,
        S_RUN        = 3'd4
`ifdef RST_SEQ_WDOG_EN
        , S_MMCM_RST = 3'd5
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sync_q;
    logic               locked_s;
    logic               rst_serdes_q, rst_serdes_d;
    logic               rst_core_q, rst_core_d;
    logic               ready_q, ready_d;
    logic               lost_lock_q, lost_lock_d;

    assign locked_s = sync_q[1];

    always_ff @(posedge i_sclk or posedge i_arst) begin
        if (i_arst) begin
            sync_q       <= 2'b00;
            state_q      <= S_HOLD;
            cnt_q        <= '0;
            rst_serdes_q <= P_SRST_POLARITY;
            rst_core_q   <= P_SRST_POLARITY;
            ready_q      <= 1'b0;
            lost_lock_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], i_locked};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rst_serdes_q <= rst_serdes_d;
            rst_core_q   <= rst_core_d;
            ready_q      <= ready_d;
            lost_lock_q  <= lost_lock_d;
        end
    end

`ifdef RST_SEQ_WDOG_EN
    localparam int WDOG_W = (P_WDOG_CYCLES > 1) ? $clog2(P_WDOG_CYCLES) : 1;

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              mmcm_rst_q, mmcm_rst_d;
    logic [3:0]        retry_q, retry_d;

    always_ff @(posedge i_sclk or posedge i_arst) begin
        if (i_arst) begin
            wdog_q     <= '0;
            mmcm_rst_q <= 1'b0;
            retry_q    <= 4'd0;
        end else begin
            wdog_q     <= wdog_d;
            mmcm_rst_q <= mmcm_rst_d;
            retry_q    <= retry_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rst_serdes_d = rst_serdes_q;
        rst_core_d   = rst_core_q;
        ready_d      = ready_q;
        lost_lock_d  = 1'b0;
`ifdef RST_SEQ_WDOG_EN
        wdog_d       = wdog_q;
        mmcm_rst_d   = mmcm_rst_q;
        retry_d      = retry_q;
`endif
        case (state_q)
            S_HOLD: state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(P_LOCK_CYCLES - 1)) begin
                    state_d      = S_REL_SERDES;
                    cnt_d        = '0;
                    rst_serdes_d = ~P_SRST_POLARITY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REL_SERDES: begin
                if (!locked_s) begin
                    state_d      = S_WAIT_LOCK;
                    cnt_d        = '0;
                    rst_serdes_d = P_SRST_POLARITY;
                end else if (cnt_q == CNT_W'(P_STAGE_CYCLES - 1)) begin
                    state_d    = S_RUN;
                    cnt_d      = '0;
                    rst_core_d = ~P_SRST_POLARITY;
                    ready_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d      = S_WAIT_LOCK;
                    cnt_d        = '0;
                    rst_serdes_d = P_SRST_POLARITY;
                    rst_core_d   = P_SRST_POLARITY;
                    ready_d      = 1'b0;
                    lost_lock_d  = 1'b1;
                end
            end
`ifdef RST_SEQ_WDOG_EN
            S_MMCM_RST: begin
                // Lock is deliberately ignored here; the MMCM is being reset.
                if (cnt_q == CNT_W'(P_MMCM_RST_CYCLES - 1)) begin
                    state_d    = S_WAIT_LOCK;
                    cnt_d      = '0;
                    mmcm_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: state_d = S_HOLD;
        endcase
`ifdef RST_SEQ_WDOG_EN
        // Watchdog timeout overrides the lock-wait decisions made above.
        if (state_q == S_WAIT_LOCK || state_q == S_STABLE) begin
            if (wdog_q == WDOG_W'(P_WDOG_CYCLES - 1)) begin
                state_d      = S_MMCM_RST;
                cnt_d        = '0;
                wdog_d       = '0;
                rst_serdes_d = P_SRST_POLARITY;
                mmcm_rst_d   = 1'b1;
                retry_d      = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
            end else if (state_d == S_REL_SERDES) begin
                wdog_d = '0;
            end else begin
                wdog_d = wdog_q + WDOG_W'(1);
            end
        end
`endif
    end

    assign o_rst_serdes = rst_serdes_q;
    assign o_rst_core   = rst_core_q;
    assign o_ready      = ready_q;
    assign o_lost_lock  = lost_lock_q;
    assign o_dbg_state  = state_q;
`ifdef RST_SEQ_WDOG_EN
    assign o_mmcm_rst   = mmcm_rst_q;
    assign o_retry_cnt  = retry_q;
`else
    assign o_mmcm_rst   = 1'b0;
    assign o_retry_cnt  = 4'd0;
`endif

endmodule
